// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: samples the keycode once per VGA frame, then steps the ball with wall bounce.
// Optional pause-on-space feature is enabled by defining BALL_PAUSE_EN.
module ball_motion_ctrl #(
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int STEP     = 1,
    parameter int SIZE     = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_vs,
    input  logic [15:0] keycode,
    output logic [9:0]  BallX,
    output logic [9:0]  BallY,
    output logic [9:0]  BallS,
    output logic        frame_tick,
    output logic        paused
);

    localparam logic [9:0] X_CENTER_W = 10'(X_CENTER);
    localparam logic [9:0] Y_CENTER_W = 10'(Y_CENTER);
    localparam logic [9:0] X_MAX_W    = 10'(X_MAX);
    localparam logic [9:0] Y_MAX_W    = 10'(Y_MAX);
    localparam logic [9:0] X_LOW_W    = 10'(X_MIN + SIZE);
    localparam logic [9:0] Y_LOW_W    = 10'(Y_MIN + SIZE);
    localparam logic [9:0] SIZE_W     = 10'(SIZE);
    localparam logic [9:0] STEP_POS   = 10'(STEP);
    localparam logic [9:0] STEP_NEG   = 10'(-STEP);

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        BOUND  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       vs_meta_q, vs_meta_d;
    logic       vs_sync_q, vs_sync_d;
    logic       vs_prev_q, vs_prev_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic [9:0] vel_x_q, vel_x_d;
    logic [9:0] vel_y_q, vel_y_d;
    logic       frame_tick_q, frame_tick_d;
    logic       frame_start;
    logic       hold_motion;
    logic [7:0] key;
    logic       key_hi_unused;

`ifdef BALL_PAUSE_EN
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    logic       paused_q, paused_d;
    logic [7:0] prev_key_q, prev_key_d;
`endif

    assign key           = keycode[7:0];
    assign key_hi_unused = ^keycode[15:8];
    // Rising edge of the synchronized VS marks the end of the sync pulse.
    assign frame_start   = vs_sync_q & ~vs_prev_q;

    // NOTE: every variable gets a default at the top so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        vs_meta_d    = frame_vs;
        vs_sync_d    = vs_meta_q;
        vs_prev_d    = vs_sync_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        vel_x_d      = vel_x_q;
        vel_y_d      = vel_y_q;
        frame_tick_d = 1'b0;
        hold_motion  = 1'b0;
`ifdef BALL_PAUSE_EN
        paused_d     = paused_q;
        prev_key_d   = prev_key_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (frame_start) state_d = SAMPLE;
            end
            SAMPLE: begin
`ifdef BALL_PAUSE_EN
                if (key == KEY_SPACE && prev_key_q != KEY_SPACE) paused_d = ~paused_q;
                prev_key_d  = key;
                hold_motion = paused_d;
`endif
                if (!hold_motion) begin
                    case (key)
                        KEY_W:   begin vel_x_d = '0;       vel_y_d = STEP_NEG; end
                        KEY_S:   begin vel_x_d = '0;       vel_y_d = STEP_POS; end
                        KEY_A:   begin vel_x_d = STEP_NEG; vel_y_d = '0;       end
                        KEY_D:   begin vel_x_d = STEP_POS; vel_y_d = '0;       end
                        default: ;
                    endcase
                end
                state_d = BOUND;
            end
            BOUND: begin
`ifdef BALL_PAUSE_EN
                hold_motion = paused_q;
`endif
                // Walls override the key; the new position is loaded as we enter COMMIT.
                if (!hold_motion) begin
                    if (ball_y_q + SIZE_W >= Y_MAX_W) vel_y_d = STEP_NEG;
                    else if (ball_y_q <= Y_LOW_W)     vel_y_d = STEP_POS;
                    if (ball_x_q + SIZE_W >= X_MAX_W) vel_x_d = STEP_NEG;
                    else if (ball_x_q <= X_LOW_W)     vel_x_d = STEP_POS;
                    ball_x_d = ball_x_q + vel_x_d;
                    ball_y_d = ball_y_q + vel_y_d;
                end
                frame_tick_d = 1'b1;
                state_d      = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            vs_meta_q    <= 1'b1;
            vs_sync_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            ball_x_q     <= X_CENTER_W;
            ball_y_q     <= Y_CENTER_W;
            vel_x_q      <= '0;
            vel_y_q      <= '0;
            frame_tick_q <= 1'b0;
`ifdef BALL_PAUSE_EN
            paused_q     <= 1'b0;
            prev_key_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            vs_meta_q    <= vs_meta_d;
            vs_sync_q    <= vs_sync_d;
            vs_prev_q    <= vs_prev_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            vel_x_q      <= vel_x_d;
            vel_y_q      <= vel_y_d;
            frame_tick_q <= frame_tick_d;
`ifdef BALL_PAUSE_EN
            paused_q     <= paused_d;
            prev_key_q   <= prev_key_d;
`endif
        end
    end

    assign BallX      = ball_x_q;
    assign BallY      = ball_y_q;
    assign BallS      = SIZE_W;
    assign frame_tick = frame_tick_q;
`ifdef BALL_PAUSE_EN
    assign paused     = paused_q;
`else
    assign paused     = 1'b0;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: each VS pulse pushes the model's expected position; a monitor checks each frame_tick.
module tb_ball_motion_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_vs = 1'b1;
    logic [15:0] keycode = '0;
    logic [9:0]  BallX, BallY, BallS;
    logic        frame_tick, paused;

    ball_motion_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs), .keycode(keycode),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .frame_tick(frame_tick), .paused(paused)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: ball state in plain integers.
    int m_x, m_y, m_vx, m_vy, m_paused, m_prev;

    function automatic void model_reset();
        m_x = 320; m_y = 240; m_vx = 0; m_vy = 0; m_paused = 0; m_prev = 0;
    endfunction

    function automatic void model_frame(input int key);
        int nvx, nvy;
`ifdef BALL_PAUSE_EN
        if (key == 'h2C && m_prev != 'h2C) m_paused = 1 - m_paused;
        m_prev = key;
`endif
        if (m_paused == 0) begin
            nvx = m_vx; nvy = m_vy;
            if (key == 'h1A)      begin nvx = 0;  nvy = -1; end
            else if (key == 'h16) begin nvx = 0;  nvy = 1;  end
            else if (key == 'h04) begin nvx = -1; nvy = 0;  end
            else if (key == 'h07) begin nvx = 1;  nvy = 0;  end
            if (m_y + 4 >= 479)   nvy = -1;
            else if (m_y <= 4)    nvy = 1;
            if (m_x + 4 >= 639)   nvx = -1;
            else if (m_x <= 4)    nvx = 1;
            m_vx = nvx; m_vy = nvy;
            m_x = (m_x + m_vx) & 1023;
            m_y = (m_y + m_vy) & 1023;
        end
    endfunction

    typedef struct {
        int x;
        int y;
        int p;
        int tick_cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called right after frame_vs rises: tick is due 5 edges later (2 sync + SAMPLE + BOUND + COMMIT entry).
    task automatic push_expect(input int key);
        exp_t e;
        model_frame(key);
        e.x = m_x; e.y = m_y; e.p = m_paused; e.tick_cyc = cyc + 5;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) step();
        check(name, sb_q.size(), 0);
    endtask

    task automatic vs_frame(input int key);
        keycode = {8'($urandom), 8'(key)};
        frame_vs = 1'b0;
        repeat (3) step();
        frame_vs = 1'b1;
        push_expect(key);
        repeat (4) step();
        keycode = 16'($urandom);
        wait_drain("tick_seen");
        repeat ($urandom_range(0, 3)) step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) step();
        Reset = 1'b0;
        model_reset();
    endtask

    always @(negedge Clk) begin
        if (!Reset && frame_tick) begin
            if (sb_q.size() == 0) begin
                check("unexpected_tick", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ball_x", int'(BallX), e.x);
                check("ball_y", int'(BallY), e.y);
                check("paused", int'(paused), e.p);
                check("tick_latency", cyc, e.tick_cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        do_reset();
        step();
        check("rst_x", int'(BallX), 320);
        check("rst_y", int'(BallY), 240);
        check("rst_s", int'(BallS), 4);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_paused", int'(paused), 0);

        vs_frame('h07);
        vs_frame('h1A);
        for (int i = 0; i < 5; i++) vs_frame('h00);

        // Two VS rising edges one cycle apart: only the first starts a frame.
        keycode = 16'h0016;
        frame_vs = 1'b0;
        repeat (3) step();
        frame_vs = 1'b1;
        push_expect('h16);
        step();
        frame_vs = 1'b0;
        step();
        frame_vs = 1'b1;
        repeat (15) step();
        check("double_edge_drain", sb_q.size(), 0);

        // Reset while in BOUND aborts the frame.
        keycode = 16'h0004;
        frame_vs = 1'b0;
        repeat (3) step();
        frame_vs = 1'b1;
        repeat (4) step();
        Reset = 1'b1;
        step();
        check("bound_rst_x", int'(BallX), 320);
        check("bound_rst_y", int'(BallY), 240);
        check("bound_rst_tick", int'(frame_tick), 0);
        Reset = 1'b0;
        model_reset();
        repeat (3) step();
        vs_frame('h00);
        vs_frame('h07);

        do_reset();
        for (int i = 0; i < 239; i++) vs_frame('h16);
        check("bottom_y", m_y, 475);
        check("bottom_dut_y", int'(BallY), 475);

        do_reset();
        for (int i = 0; i < 320; i++) vs_frame('h07);
        do_reset();
        for (int i = 0; i < 320; i++) vs_frame('h04);

`ifdef BALL_PAUSE_EN
        do_reset();
        vs_frame('h07);
        vs_frame('h2C);
        for (int i = 0; i < 3; i++) vs_frame('h2C);
        vs_frame('h00);
        vs_frame('h2C);
        vs_frame('h00);
`endif

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    vs_frame('h1A);
                2:       vs_frame('h16);
                3:       vs_frame('h04);
                4:       vs_frame('h07);
                5:       vs_frame('h00);
                6:       vs_frame('h2C);
                default: vs_frame(int'($urandom_range(0, 255)));
            endcase
        end

        repeat (10) step();
        check("final_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
